// File: rtl/latq_bank_wr_sched_if.sv
// Requester-side bus of the latch-bank write scheduler.
// LATQ_WR_PARITY_EN widens D by one even-parity bit.
interface latq_bank_wr_sched_if #(
   parameter int NREQ   = 4,
   parameter int NWORDS = 8,
   parameter int AW     = 4,
   parameter int DW     = 8
);
`ifdef LATQ_WR_PARITY_EN
   localparam int DPW = DW + 1;
`else
   localparam int DPW = DW;
`endif

   // REQ is a level "valid" held with ADDR/WDATA until sampled in IDLE; GNT is
   // the one-cycle "ready" pulse, after which the requester drops REQ or is re-served.
   logic [NREQ-1:0]    REQ;
   logic [NREQ*AW-1:0] ADDR;
   logic [NREQ*DW-1:0] WDATA;
   logic [NREQ-1:0]    GNT;
   logic [DPW-1:0]     D;
   logic [NWORDS-1:0]  E;
   logic               BUSY;
   logic               ERR;
   logic [1:0]         state_dbg;

   modport master (
      output REQ, ADDR, WDATA,
      input  GNT, D, E, BUSY, ERR, state_dbg
   );

   modport slave (
      input  REQ, ADDR, WDATA,
      output GNT, D, E, BUSY, ERR, state_dbg
   );
endinterface

// File: rtl/latq_bank_wr_sched.sv
// Round-robin write scheduler for a latch bank: setup / enable-pulse / hold per write.
// Optional LATQ_WR_PARITY_EN appends an even-parity bit to the D bus.
module latq_bank_wr_sched #(
   parameter int NREQ   = 4,
   parameter int NWORDS = 8,
   parameter int AW     = 4,
   parameter int DW     = 8
) (
   input  logic               CLK,
   input  logic               RST,
   latq_bank_wr_sched_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef LATQ_WR_PARITY_EN
   localparam int DPW = DW + 1;
`else
   localparam int DPW = DW;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t            state;
   logic [PW-1:0]     ptr;
   logic [AW-1:0]     addr_q;
   logic [NREQ-1:0]   gnt_q;
   logic [DPW-1:0]    d_q;
   logic [NWORDS-1:0] e_q;
   logic              busy_q;
   logic              err_q;

   logic              found;
   logic [PW-1:0]     win;
   logic [PW-1:0]     ptr_nxt;
   logic [AW-1:0]     addr_sel;
   logic [DW-1:0]     wdata_sel;
   logic [DPW-1:0]    d_nxt;
   logic              in_range;
   int                idx;

   // Search starts at the pointer and wraps, so the last winner gets lowest priority.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && bus.REQ[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   always_comb begin
      ptr_nxt   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
      addr_sel  = bus.ADDR[win*AW +: AW];
      wdata_sel = bus.WDATA[win*DW +: DW];
`ifdef LATQ_WR_PARITY_EN
      d_nxt     = {^wdata_sel, wdata_sel};
`else
      d_nxt     = wdata_sel;
`endif
   end

   // Full address width is compared so unused high codes are flagged, not aliased.
   assign in_range = ({1'b0, addr_q} < (AW+1)'(NWORDS));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         ptr    <= '0;
         addr_q <= '0;
         gnt_q  <= '0;
         d_q    <= '0;
         e_q    <= '0;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         gnt_q <= '0;
         e_q   <= '0;
         err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  addr_q <= addr_sel;
                  d_q    <= d_nxt;
                  gnt_q  <= NREQ'(1) << win;
                  ptr    <= ptr_nxt;
                  busy_q <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               if (in_range) e_q <= NWORDS'(1) << addr_q;
               else          err_q <= 1'b1;
               state <= PULSE;
            end
            PULSE: state <= HOLD;
            HOLD: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.GNT       = gnt_q;
   assign bus.D         = d_q;
   assign bus.E         = e_q;
   assign bus.BUSY      = busy_q;
   assign bus.ERR       = err_q;
   assign bus.state_dbg = state;
endmodule

// File: doc/latq_bank_wr_sched.md
Name: latq_bank_wr_sched

Overview:
- Write scheduler for a bank of NWORDS latch words, each word DW latq cells sharing one enable.
- Shares the single bank write path between NREQ requesters using round-robin arbitration.
- Sequences each write as data-setup, enable-pulse, data-hold, so every latch sees stable D around its E window.
- Sits between requester logic and the latch bank. It drives the shared D bus and the one-hot per-word E lines.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NWORDS, 8, number of latch words (2..16).
- AW, 4, address width; must satisfy 2**AW >= NWORDS.
- DW, 8, data width per word.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous active-high reset.
- REQ  input  NREQ  per-requester write request, level.
- ADDR  input  NREQ*AW  flattened word addresses; requester i uses bits [i*AW +: AW].
- WDATA  input  NREQ*DW  flattened write data; requester i uses bits [i*DW +: DW].
- GNT  output  NREQ  one-hot, one-cycle grant pulse.
- D  output  DW (DW+1 with parity)  shared data bus to the latch bank.
- E  output  NWORDS  one-hot latch enables, active-high.
- BUSY  output  1  high whenever state != IDLE.
- ERR  output  1  one-cycle pulse when a granted address is >= NWORDS.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Registered outputs: all outputs come from flops, so E is glitch-free.
- Reset values: GNT=0, D=0, E=0, BUSY=0, ERR=0, state=IDLE, round-robin pointer=0.
  - RST is sampled at the edge; outputs take reset values in the following cycle.
  - If a write is in progress when RST is sampled, E drops and the write is abandoned. No GNT is re-issued.
- States: IDLE, SETUP, PULSE, HOLD.
- IDLE:
  - If any REQ bit is set, pick the winner by round-robin. Search starts at pointer p and wraps modulo NREQ.
  - At that edge: capture the winner's ADDR and WDATA into internal registers, load D from captured WDATA, go to SETUP.
  - If no REQ bit is set, stay in IDLE.
- SETUP:
  - GNT[winner]=1 for this cycle only.
  - D is stable and E=0.
  - Pointer p <= winner+1, modulo NREQ.
  - Next state: PULSE.
- PULSE:
  - E[addr]=1 for exactly one cycle.
  - If addr >= NWORDS: E stays all-zero and ERR=1 this cycle.
  - D is unchanged. Next state: HOLD.
- HOLD:
  - E=0 and D is still held, giving one cycle of hold after E falls.
  - Next state: IDLE.
- Throughput: fixed 4 cycles per write (IDLE, SETUP, PULSE, HOLD). Maximum one write per 4 cycles.
- Latency: REQ sampled in IDLE at edge t gives GNT high in cycle t+1 and E high in cycle t+2.
- D between writes: retains the last written value; D is not zeroed.
- Requester obligations:
  - Hold REQ, ADDR and WDATA stable until the sampling edge.
  - Drop REQ after GNT, or the requester is eligible again on the next IDLE.
- Withdrawal: a REQ dropped before it is sampled is simply not served.
- Requests arriving while BUSY are ignored until the next IDLE; nothing is queued.
- Fairness: with all REQ bits held high, grants rotate 0,1,…,NREQ-1,0,…
- Pointer and unused bits:
  - The pointer advances only on a grant.
  - ADDR bits above the range are still compared, so the out-of-range check covers every value that does not fit in NWORDS.

Optional Feature:
- LATQ_WR_PARITY_EN defined:
  - D is DW+1 bits wide. D[DW] = even parity of the captured data (XOR of D[DW-1:0]).
  - The parity bit is registered with the data and follows the same setup and hold timing.
- Undefined: D is DW bits wide and there is no parity logic.

Test Plan:
- Single write: RST for 2 cycles, then REQ=4'b0010, ADDR1=3, WDATA1=8'hA5. Required: GNT=4'b0010 one cycle later, then E=8'b0000_1000 for one cycle with D=8'hA5. D=8'hA5 must hold from the GNT cycle until after E falls. BUSY high for 3 cycles.
- Round-robin: REQ=4'b1111 held, ADDRi=i. Required grant order 0,1,2,3,0, with GNT pulses 4 cycles apart and E rotating 8'h01, 8'h02, 8'h04, 8'h08.
- Out-of-range: ADDR0=9 with NWORDS=8. Required: GNT[0] pulses, E stays 0 throughout, ERR=1 in the PULSE cycle. The pointer still advances to 1.
- Reset mid-write: assert RST during the PULSE cycle of a write to word 5. Required next cycle: E=0, BUSY=0, GNT=0, D=0. No later E pulse occurs for that request unless it is re-requested.
- Request while busy: REQ2 raised during SETUP of requester 0's write. Required: REQ2 is not granted until the cycle after HOLD, with GNT[2] at +4 cycles from GNT[0].
- Parity (LATQ_WR_PARITY_EN): WDATA=8'h07 gives D[8]=1; WDATA=8'h03 gives D[8]=0. Both are stable from SETUP through HOLD.
